// File: rtl/fir_serial_mac.sv
// fir_serial_mac
// Time-multiplexed FIR filter built around one shared multiply-accumulate.
// One sample is accepted through a valid/ready handshake. The MAC then walks
// all N_TAPS products, one per clock. The rounded and saturated result is
// presented with a one-cycle strobe.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       synchronous reset, active low
//   in_valid    in_data holds a sample
//   in_ready    block can accept a sample this cycle
//   in_data     signed input sample (DATA_W)
//   coef_we     coefficient write strobe (honoured in IDLE only)
//   coef_addr   tap index, 0 = newest sample
//   coef_wdata  signed coefficient (COEF_W)
//   out_valid   one-cycle strobe, out_data/out_sat valid
//   out_data    signed filtered sample (OUT_W)
//   out_sat     out_data was clipped
module fir_serial_mac #(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int N_TAPS = 8,
  parameter int OUT_W  = 9,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       coef_we,
  input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat
);

  localparam int AW     = $clog2(N_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  // The result path is one bit wider than the accumulator so that adding the
  // rounding constant can never wrap.
  localparam logic signed [ACC_W:0] RND     = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;
  localparam logic [AW-1:0]         LAST    = AW'(N_TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_reg;
  logic signed [DATA_W-1:0]  x_reg    [N_TAPS];
  logic signed [COEF_W-1:0]  coef_reg [N_TAPS];
  logic signed [ACC_W-1:0]   acc_reg;
  logic [AW-1:0]             cnt_reg;

  logic                      accept;
  logic                      coef_en;
  logic [N_TAPS-1:0]         coef_hit;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     sum_ext;
  logic signed [ACC_W:0]     res;
  logic [OUT_W-1:0]          sat_data_next;
  logic                      sat_flag_next;

  // The ready signal is forced low while reset is held.
  assign in_ready = rst_n && (state_reg == IDLE);
  assign accept   = in_valid && in_ready;

  // Coefficient writes are dropped outside IDLE. The coefficients therefore
  // stay frozen for a whole computation.
  assign coef_en  = coef_we && (state_reg == IDLE);

  // Per-tap address decode. An address at or above N_TAPS matches no tap and
  // is ignored.
  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_coef_dec
      assign coef_hit[gi] = coef_en && (coef_addr == AW'(gi));
    end
  endgenerate

  // Shared multiplier: the full-precision signed product of the current tap.
  assign prod     = x_reg[cnt_reg] * coef_reg[cnt_reg];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Rounding (half toward +inf), arithmetic shift, then saturation.
  always_comb begin
    sum_ext       = {acc_reg[ACC_W-1], acc_reg} + RND;
    res           = sum_ext >>> SHIFT;
    sat_data_next = res[OUT_W-1:0];
    sat_flag_next = 1'b0;
    if (res > OUT_MAX) begin
      sat_data_next = OUT_MAX[OUT_W-1:0];
      sat_flag_next = 1'b1;
    end else if (res < OUT_MIN) begin
      sat_data_next = OUT_MIN[OUT_W-1:0];
      sat_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        x_reg[i]    <= '0;
        coef_reg[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;

      // A write in the same cycle as an acceptance lands now. The MAC reads
      // the coefficients only from the next cycle on, so it sees the new value.
      for (int i = 0; i < N_TAPS; i++) begin
        if (coef_hit[i]) begin
          coef_reg[i] <= coef_wdata;
        end
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            x_reg[0] <= in_data;
            for (int i = 1; i < N_TAPS; i++) begin
              x_reg[i] <= x_reg[i-1];
            end
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg <= OUT;
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= sat_data_next;
          out_sat   <= sat_flag_next;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac
// Three filters with 4 taps share one stimulus. They differ only in their
// output stage:
//   w: OUT_W=20, SHIFT=0  (impulse, step, handshake, reset)
//   n: OUT_W=9,  SHIFT=0  (saturation)
//   r: OUT_W=9,  SHIFT=2  (rounding)
module tb_fir_serial_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [8:0]        in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [8:0]        coef_wdata;

  logic              w_ready, w_valid, w_sat;
  logic signed [19:0] w_data;
  logic              n_ready, n_valid, n_sat;
  logic signed [8:0] n_data;
  logic              r_ready, r_valid, r_sat;
  logic signed [8:0] r_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_serial_mac #(.DATA_W(9), .COEF_W(9), .N_TAPS(4), .OUT_W(20), .SHIFT(0)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(w_valid), .out_data(w_data), .out_sat(w_sat));

  fir_serial_mac #(.DATA_W(9), .COEF_W(9), .N_TAPS(4), .OUT_W(9), .SHIFT(0)) u_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(n_valid), .out_data(n_data), .out_sat(n_sat));

  fir_serial_mac #(.DATA_W(9), .COEF_W(9), .N_TAPS(4), .OUT_W(9), .SHIFT(2)) u_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(r_valid), .out_data(r_data), .out_sat(r_sat));

  typedef struct {
    int cset;      // coefficient set loaded before the sample, -1 = keep
    int sample;
    int sel;       // 0 = w, 1 = n, 2 = r
    int exp_data;
    int exp_sat;
  } vec_t;

  int   csets [3][4];
  vec_t vecs  [30];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 2'(i);
      coef_wdata = 9'(c[i]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offers one sample and waits for its result.
  // mode 0 = no coefficient write
  // mode 1 = write in the acceptance cycle
  // mode 2 = write during the first MAC cycle
  // lat counts cycles from the acceptance edge to out_valid.
  task automatic do_sample(input int s, input int mode, input int addr, input int wd,
                           output int dw, output int dn, output int dr,
                           output int sw, output int sn, output int sr, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 9'(s);
    if (mode == 1) begin
      coef_we = 1'b1; coef_addr = 2'(addr); coef_wdata = 9'(wd);
    end
    for (int w = 0; w < 20 && !w_ready; w++) @(negedge clk);
    if (!w_ready) check("in_ready_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (mode == 2) begin
      coef_we = 1'b1; coef_addr = 2'(addr); coef_wdata = 9'(wd);
    end
    lat = 1;
    while (!w_valid && lat < 20) begin
      @(negedge clk);
      coef_we = 1'b0;
      lat++;
    end
    dw = int'(w_data); dn = int'(n_data); dr = int'(r_data);
    sw = int'(w_sat);  sn = int'(n_sat);  sr = int'(r_sat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dw, dn, dr, sw, sn, sr, lat, got, gots;
    int last_acc, n_acc, n_pulse, pulses;
    string nm;

    csets[0] = '{1, 2, 3, 4};
    csets[1] = '{127, 127, 127, 127};
    csets[2] = '{1, 0, 0, 0};

    // impulse
    vecs[0]  = '{0, 1, 0, 1, 0};
    vecs[1]  = '{-1, 0, 0, 2, 0};
    vecs[2]  = '{-1, 0, 0, 3, 0};
    vecs[3]  = '{-1, 0, 0, 4, 0};
    vecs[4]  = '{-1, 0, 0, 0, 0};
    // step
    vecs[5]  = '{-1, 10, 0, 10, 0};
    vecs[6]  = '{-1, 10, 0, 30, 0};
    vecs[7]  = '{-1, 10, 0, 60, 0};
    vecs[8]  = '{-1, 10, 0, 100, 0};
    vecs[9]  = '{-1, 10, 0, 100, 0};
    // saturation, 9-bit output
    vecs[10] = '{1, 255, 1, 255, 1};
    vecs[11] = '{-1, 255, 1, 255, 1};
    vecs[12] = '{-1, 255, 1, 255, 1};
    vecs[13] = '{-1, 255, 1, 255, 1};
    vecs[14] = '{-1, -256, 1, 255, 1};
    vecs[15] = '{-1, -256, 1, -254, 0};
    vecs[16] = '{-1, -256, 1, -256, 1};
    vecs[17] = '{-1, -256, 1, -256, 1};
    // rounding, SHIFT=2
    vecs[18] = '{2, 6, 2, 2, 0};
    vecs[19] = '{-1, -6, 2, -1, 0};
    vecs[20] = '{-1, 5, 2, 1, 0};
    vecs[21] = '{-1, -5, 2, -1, 0};
    vecs[22] = '{-1, 2, 2, 1, 0};
    vecs[23] = '{-1, -2, 2, 0, 0};
    vecs[24] = '{-1, -2, 1, -2, 0};
    vecs[25] = '{-1, 7, 2, 2, 0};
    vecs[26] = '{-1, 255, 1, 255, 0};
    vecs[27] = '{-1, 255, 2, 64, 0};
    vecs[28] = '{-1, -256, 2, -64, 0};
    vecs[29] = '{-1, -256, 1, -256, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(w_ready), 0);
    check("rst_out_valid", int'(w_valid), 0);
    check("rst_out_data", int'(w_data), 0);
    check("rst_out_sat", int'(n_sat), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(w_ready), 1);

    // Table-driven vectors
    for (int i = 0; i < 30; i++) begin
      if (vecs[i].cset >= 0)
        load_coefs(csets[vecs[i].cset][0], csets[vecs[i].cset][1],
                   csets[vecs[i].cset][2], csets[vecs[i].cset][3]);
      do_sample(vecs[i].sample, 0, 0, 0, dw, dn, dr, sw, sn, sr, lat);
      case (vecs[i].sel)
        0: begin got = dw; gots = sw; end
        1: begin got = dn; gots = sn; end
        default: begin got = dr; gots = sr; end
      endcase
      $sformat(nm, "vec%0d_data", i);
      check(nm, got, vecs[i].exp_data);
      $sformat(nm, "vec%0d_sat", i);
      check(nm, gots, vecs[i].exp_sat);
      $sformat(nm, "vec%0d_latency", i);
      check(nm, lat, 6);
    end

    // Handshake: in_valid held high for 24 cycles.
    load_coefs(1, 2, 3, 4);
    last_acc = -1; n_acc = 0; n_pulse = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = '0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (w_valid) n_pulse++;
      if (w_ready) begin
        if (last_acc >= 0) begin
          $sformat(nm, "hs_gap_at_%0d", c);
          check(nm, c - last_acc, 6);
        end
        last_acc = c;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    check("hs_acceptances", n_acc, 4);
    check("hs_out_pulses", n_pulse, 3);
    repeat (4) @(negedge clk);

    // Coefficient guard: a write during MAC is dropped, a write in the
    // acceptance cycle is used.
    do_sample(1, 2, 0, 100, dw, dn, dr, sw, sn, sr, lat);
    check("guard_mac_write", dw, 1);
    do_sample(0, 0, 0, 0, dw, dn, dr, sw, sn, sr, lat);
    check("guard_next_output", dw, 2);
    do_sample(3, 1, 0, 7, dw, dn, dr, sw, sn, sr, lat);
    check("write_then_accept", dw, 24);

    // Reset while the MAC is at cnt=2
    @(negedge clk);
    in_valid = 1'b1; in_data = 9'(5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready_low", int'(w_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", int'(w_ready), 1);
    check("midrst_out_data", int'(w_data), 0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_valid) pulses++;
    end
    check("midrst_no_out_valid", pulses, 0);
    do_sample(1, 0, 0, 0, dw, dn, dr, sw, sn, sr, lat);
    check("midrst_coefs_cleared", dw, 0);
    load_coefs(0, 1, 1, 1);
    do_sample(0, 0, 0, 0, dw, dn, dr, sw, sn, sr, lat);
    check("midrst_delay_cleared", dw, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
